rs_link_arb: RTL and testbench
==============================

RS_LINK_ARB -- requirements
Module: rs_link_arb

Interface
REQ-001 Parameter PAYLOAD_BITS, default 32: width of one data beat; SHALL be legal for 1..512.
REQ-002 Parameter NUM_REQ, default 4: number of requesters; SHALL be legal for 2..8.
REQ-003 Parameter CREDITS, default 8: receiver buffer depth in beats; SHALL be legal for 1..255.
REQ-004 ap_clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 ap_rst  in  1  reset, synchronous and active-high.
REQ-006 req_din  in  NUM_REQ*PAYLOAD_BITS  requester payloads; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-007 req_vld  in  NUM_REQ  per-requester beat valid.
REQ-008 req_last  in  NUM_REQ  per-requester last beat of packet.
REQ-009 req_rdy  out  NUM_REQ  per-requester beat accepted this cycle.
REQ-010 link_dout  out  PAYLOAD_BITS  registered beat driven into the downstream pipeline-register chain.
REQ-011 link_vld  out  1  link_dout qualifier; this is a push with no backpressure.
REQ-012 link_last  out  1  registered copy of the accepted req_last.
REQ-013 link_src  out  max(1,clog2(NUM_REQ))  index of the requester that sourced the beat.
REQ-014 credit_ret  in  1  one-cycle pulse from the receiver per buffer entry freed.
REQ-015 credit_cnt  out  8  current available credits.
REQ-016 cred_err  out  1  sticky credit-overflow flag.
REQ-017 stall_cnt  out  32  stall statistics counter (see Configuration).

Function
REQ-018 The block SHALL implement a two-state FSM: IDLE (no grant held) and LOCK (grant held by requester g).
REQ-019 In IDLE, the arbiter SHALL pick the first requester with req_vld=1, scanning round-robin from (last_grant+1) mod NUM_REQ; the pick and the first beat SHALL occur in the same cycle.
REQ-020 A beat from requester i SHALL be accepted (req_rdy[i]=1) only when i is the granted/picked requester, req_vld[i]=1, and credit_cnt>0; all other req_rdy bits SHALL be 0.
REQ-021 On acceptance of a beat with req_last=0, the FSM SHALL enter or remain in LOCK on that requester; with req_last=1, it SHALL go to IDLE and set last_grant to that requester.
REQ-022 In LOCK, other requesters SHALL NOT be granted even when the owner deasserts req_vld; the grant SHALL persist until the owner's last beat is accepted.
REQ-023 Latency: an accepted beat SHALL appear on link_dout/link_vld/link_last/link_src exactly one cycle after acceptance; link_vld SHALL be 0 in cycles following non-acceptance.
REQ-024 credit_cnt SHALL be decremented by 1 per accepted beat and incremented by 1 per credit_ret pulse; when both occur in one cycle it SHALL be unchanged.
REQ-025 credit_ret with credit_cnt=CREDITS and no acceptance SHALL leave credit_cnt at CREDITS and set cred_err to 1 until reset.
REQ-026 With credit_cnt=0, no beat SHALL be accepted; a credit_ret in that cycle SHALL become usable the following cycle (no combinational credit_ret-to-req_rdy path).
REQ-027 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-028 While ap_rst=1 at a clock edge: FSM SHALL be set to IDLE, last_grant to NUM_REQ-1 (so requester 0 has first priority), credit_cnt to CREDITS, link_vld/link_last/cred_err to 0, link_dout/link_src to 0, stall_cnt to 0.
REQ-029 req_rdy SHALL be all-zero during any cycle with ap_rst=1.
REQ-030 Reset asserted mid-packet SHALL abandon the lock; no partial-packet recovery is required.

Configuration
REQ-031 With macro RS_LINK_ARB_STALL_CNT_EN defined, stall_cnt SHALL increment each cycle in which any req_vld=1 and credit_cnt=0, saturating at 2^32-1.
REQ-032 Without RS_LINK_ARB_STALL_CNT_EN, stall_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-033 Reset, then req_vld=4'b1111, all req_last=1, credit_ret pulsed every cycle -> grants 0,1,2,3,0 in successive cycles; link_src follows one cycle later.
REQ-034 Requester 2 sends a 3-beat packet while requester 0 is valid and requester 2 idles one cycle mid-packet -> requester 0 gets no req_rdy until requester 2's last beat is accepted.
REQ-035 CREDITS=8, no credit_ret, 10 single-beat packets offered -> exactly 8 accepted, credit_cnt=0, req_rdy all-zero afterwards; one credit_ret -> exactly one more beat accepted, on the following cycle.
REQ-036 Acceptance and credit_ret in the same cycle with credit_cnt=5 -> credit_cnt stays 5; credit_ret with credit_cnt=8 and idle -> credit_cnt=8, cred_err=1 held.
REQ-037 ap_rst pulsed mid-packet of requester 1 -> next cycle IDLE, credit_cnt=8, link_vld=0, and requester 0 wins the next arbitration.
REQ-038 With RS_LINK_ARB_STALL_CNT_EN, hold credits at 0 with req_vld=1 for 7 cycles -> stall_cnt=7; without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/rs_link_arb.sv
// Credit-gated round-robin packet arbiter: N requesters onto one registered push link, grant locked until last beat.
// Optional stall statistics counter enabled by defining RS_LINK_ARB_STALL_CNT_EN.
module rs_link_arb #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int CREDITS      = 8
) (
  input  logic                                           ap_clk,
  input  logic                                           ap_rst,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0]                req_din,
  input  logic [NUM_REQ-1:0]                             req_vld,
  input  logic [NUM_REQ-1:0]                             req_last,
  output logic [NUM_REQ-1:0]                             req_rdy,
  output logic [PAYLOAD_BITS-1:0]                        link_dout,
  output logic                                           link_vld,
  output logic                                           link_last,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] link_src,
  input  logic                                           credit_ret,
  output logic [7:0]                                     credit_cnt,
  output logic                                           cred_err,
  output logic [31:0]                                    stall_cnt
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  localparam logic [7:0] CRED_MAX = 8'(CREDITS);

  logic [0:0]              state;
  logic [SRC_W-1:0]        last_grant;
  logic [SRC_W-1:0]        pick;
  logic [SRC_W-1:0]        idx_s;
  logic                    pick_vld;
  logic                    pick_last;
  logic [PAYLOAD_BITS-1:0] pick_dat;
  logic                    accept;
  int                      idx;

  // last_grant doubles as the lock owner while in LOCK.
  // Scan runs farthest-first so the nearest valid requester after last_grant wins.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    idx      = 0;
    idx_s    = '0;
    if (state == LOCK) begin
      pick_vld = req_vld[last_grant];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx   = (int'(last_grant) + k) % NUM_REQ;
        idx_s = SRC_W'(idx);
        if (req_vld[idx_s]) begin
          pick     = idx_s;
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_dat  = '0;
    pick_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == SRC_W'(i)) begin
        pick_dat  = req_din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        pick_last = req_last[i];
      end
    end
  end

  // Gated on the registered count only, so a returning credit is usable next cycle.
  assign accept = pick_vld && (credit_cnt != 8'd0) && !ap_rst;

  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (pick == SRC_W'(i))) req_rdy[i] = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(NUM_REQ - 1);
      credit_cnt <= CRED_MAX;
      cred_err   <= 1'b0;
      link_vld   <= 1'b0;
      link_last  <= 1'b0;
      link_dout  <= '0;
      link_src   <= '0;
    end else begin
      link_vld <= accept;
      if (accept) begin
        link_dout  <= pick_dat;
        link_last  <= pick_last;
        link_src   <= pick;
        last_grant <= pick;
        state      <= pick_last ? IDLE : LOCK;
      end
      case ({accept, credit_ret})
        2'b10:   credit_cnt <= credit_cnt - 8'd1;
        2'b01: begin
          if (credit_cnt == CRED_MAX) cred_err <= 1'b1;
          else                        credit_cnt <= credit_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef RS_LINK_ARB_STALL_CNT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stall_cnt <= '0;
    end else if ((|req_vld) && (credit_cnt == 8'd0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_link_arb.sv
// Directed-vector bench for rs_link_arb with default parameters (4 requesters, 32-bit beats, 8 credits).
module tb_rs_link_arb;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic [127:0] req_din;
  logic [3:0]   req_vld;
  logic [3:0]   req_last;
  logic [3:0]   req_rdy;
  logic [31:0]  link_dout;
  logic         link_vld;
  logic         link_last;
  logic [1:0]   link_src;
  logic         credit_ret;
  logic [7:0]   credit_cnt;
  logic         cred_err;
  logic [31:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int acc;
  logic [31:0] exp_stall;

  rs_link_arb #(.PAYLOAD_BITS(32), .NUM_REQ(4), .CREDITS(8)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_din(req_din), .req_vld(req_vld), .req_last(req_last), .req_rdy(req_rdy),
    .link_dout(link_dout), .link_vld(link_vld), .link_last(link_last), .link_src(link_src),
    .credit_ret(credit_ret), .credit_cnt(credit_cnt), .cred_err(cred_err), .stall_cnt(stall_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    req_din    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    ap_rst     = 1'b1;
    req_vld    = 4'hF;
    req_last   = 4'hF;
    credit_ret = 1'b0;
    #1;
    check("rdy_in_reset", req_rdy, 4'h0);
    tick(); tick();
    check("rdy_in_reset2", req_rdy, 4'h0);
    check("rst_credit", credit_cnt, 8);
    check("rst_link_vld", link_vld, 0);
    check("rst_link_last", link_last, 0);
    check("rst_cred_err", cred_err, 0);
    check("rst_link_dout", link_dout, 0);
    check("rst_link_src", link_src, 0);
    check("rst_stall", stall_cnt, 0);

    // Round-robin with single-beat packets, credits recycled every cycle
    ap_rst     = 1'b0;
    credit_ret = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_rdy_%0d", k), req_rdy, 4'b0001 << (k % 4));
      tick();
      check($sformatf("rr_vld_%0d", k), link_vld, 1);
      check($sformatf("rr_src_%0d", k), link_src, k % 4);
      check($sformatf("rr_dout_%0d", k), link_dout, 32'hA0 + (k % 4));
      check($sformatf("rr_cred_%0d", k), credit_cnt, 8);
    end
    req_vld = 4'h0; credit_ret = 1'b0;
    tick();
    check("idle_link_vld", link_vld, 0);

    // Requester 2 holds a 3-beat packet against requester 0, idling once mid-packet
    req_vld = 4'b0101; req_last = 4'b0000;
    #1; check("lock_a_rdy", req_rdy, 4'b0100);
    tick();
    check("lock_a_last", link_last, 0);
    check("lock_a_src", link_src, 2);
    req_vld = 4'b0001;
    #1; check("lock_b_rdy", req_rdy, 4'b0000);
    tick();
    check("lock_b_vld", link_vld, 0);
    req_vld = 4'b0101; req_last = 4'b0100;
    #1; check("lock_c_rdy", req_rdy, 4'b0100);
    tick();
    check("lock_c_last", link_last, 1);
    check("lock_c_src", link_src, 2);
    req_vld = 4'b0001; req_last = 4'b0001;
    #1; check("lock_d_rdy", req_rdy, 4'b0001);
    tick();
    check("lock_d_src", link_src, 0);
    check("lock_d_cred", credit_cnt, 5);

    // Simultaneous accept and return keeps count; over-return sets sticky error
    req_vld = 4'b0010; req_last = 4'b0010; credit_ret = 1'b1;
    #1; check("same_rdy", req_rdy, 4'b0010);
    tick();
    check("same_cred", credit_cnt, 5);
    req_vld = 4'h0;
    tick(); tick(); tick();
    check("refill_cred", credit_cnt, 8);
    check("refill_err", cred_err, 0);
    tick();
    check("over_cred", credit_cnt, 8);
    check("over_err", cred_err, 1);
    credit_ret = 1'b0;
    tick(); tick();
    check("over_err_held", cred_err, 1);

    // Reset in the middle of a requester 1 packet
    req_vld = 4'b0010; req_last = 4'b0000;
    #1; check("mid_rdy", req_rdy, 4'b0010);
    tick();
    req_vld = 4'b0011; ap_rst = 1'b1;
    #1; check("mid_rst_rdy", req_rdy, 4'b0000);
    tick();
    ap_rst = 1'b0; req_last = 4'b0011;
    check("mid_rst_cred", credit_cnt, 8);
    check("mid_rst_vld", link_vld, 0);
    check("mid_rst_err", cred_err, 0);
    #1; check("mid_rst_winner", req_rdy, 4'b0001);
    tick();
    check("mid_rst_src", link_src, 0);

    // Credit exhaustion: 10 offers from a fresh reset, 8 accepted
    req_vld = 4'h0; ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0; req_vld = 4'b0001; req_last = 4'b0001;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_rdy[0]) acc++;
      tick();
    end
    check("exh_accepted", acc, 8);
    check("exh_cred", credit_cnt, 0);
    #1; check("exh_rdy", req_rdy, 4'h0);
    credit_ret = 1'b1;
    #1; check("ret_no_comb_rdy", req_rdy, 4'h0);
    tick();
    credit_ret = 1'b0;
    check("ret_cred", credit_cnt, 1);
    #1; check("ret_rdy", req_rdy, 4'b0001);
    tick();
    check("ret_used_cred", credit_cnt, 0);
    check("ret_used_vld", link_vld, 1);
    #1; check("ret_after_rdy", req_rdy, 4'h0);

    // Stall statistics: drain 8 credits, then 7 starved cycles
    req_vld = 4'h0; ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0; req_vld = 4'b0001;
    for (int c = 0; c < 8; c++) tick();
    check("stall_drained", credit_cnt, 0);
    check("stall_zero_before", stall_cnt, 0);
    for (int c = 0; c < 7; c++) tick();
    req_vld = 4'h0;
`ifdef RS_LINK_ARB_STALL_CNT_EN
    exp_stall = 32'd7;
`else
    exp_stall = 32'd0;
`endif
    check("stall_cnt", stall_cnt, exp_stall);
    tick();
    check("stall_cnt_hold", stall_cnt, exp_stall);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
